// File: rtl/aes_pkg.sv
// Shared constants for the byte-serial AES-128 controller.
// Holds the state encoding, phase sizes and the Rcon xtime helper.
package aes_pkg;

    localparam int NUM_ROUNDS  = 10;
    localparam int BYTE_CYCLES = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1B;

    localparam logic [3:0] CNT_LAST   = 4'(BYTE_CYCLES - 1);
    localparam logic [3:0] ROUND_LAST = 4'(NUM_ROUNDS);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_ctrl_fsm_if.sv
// Start request and sequencing strobes between the AES controller
// and the datapath it drives.
interface aes_ctrl_fsm_if;

    logic       StartxSI;
    logic       BusyxSO;
    logic       LoadxSO;
    logic       ShiftRowsxSO;
    logic       MixColumnsxSO;
    logic       KeyStepxSO;
    logic [7:0] RconxDO;
    logic [3:0] RoundxDO;
    logic       CipherValidxSO;
    logic       DonexSO;

    modport master (
        output StartxSI,
        input  BusyxSO, LoadxSO, ShiftRowsxSO, MixColumnsxSO,
        input  KeyStepxSO, RconxDO, RoundxDO, CipherValidxSO, DonexSO
    );

    modport slave (
        input  StartxSI,
        output BusyxSO, LoadxSO, ShiftRowsxSO, MixColumnsxSO,
        output KeyStepxSO, RconxDO, RoundxDO, CipherValidxSO, DonexSO
    );

endinterface

// File: rtl/aes_rcon_gen.sv
// Round-constant register: reload to 01 or advance by one xtime step.
module aes_rcon_gen
    import aes_pkg::*;
(
    input  logic       ClkxCI,
    input  logic       RstxBI,
    input  logic       i_load,
    input  logic       i_step,
    output logic [7:0] o_rcon
);

    logic [7:0] r_rcon;

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            r_rcon <= RCON_INIT;
        end else if (i_load) begin
            r_rcon <= RCON_INIT;
        end else if (i_step) begin
            r_rcon <= xtime(r_rcon);
        end
    end

    assign o_rcon = r_rcon;

endmodule

// File: rtl/aes_ctrl_fsm.sv
// Sequencer for the byte-serial AES-128 datapath: load, ten rounds,
// ciphertext drain, sixteen cycles per phase.
module aes_ctrl_fsm
    import aes_pkg::*;
(
    input  logic           ClkxCI,
    input  logic           RstxBI,
    aes_ctrl_fsm_if.slave  bus
);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] r_round;

    logic w_cnt_last;
    logic w_round_last;
    logic w_start;
    logic w_rcon_step;

    assign w_cnt_last   = (r_cnt == CNT_LAST);
    assign w_round_last = (r_round == ROUND_LAST);
    assign w_start      = (r_state == ST_IDLE) && bus.StartxSI;
    assign w_rcon_step  = (r_state == ST_ROUND) && w_cnt_last
                          && !w_round_last;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (bus.StartxSI) w_state_nxt = ST_LOAD;
            ST_LOAD:  if (w_cnt_last) w_state_nxt = ST_ROUND;
            ST_ROUND: if (w_cnt_last && w_round_last) w_state_nxt = ST_OUT;
            ST_OUT:   if (w_cnt_last) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Byte counter wraps 15 -> 0 at every phase boundary by itself.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_round <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (r_state == ST_IDLE) ? 4'd0 : r_cnt + 4'd1;
            unique case (r_state)
                ST_IDLE:  r_round <= 4'd0;
                ST_LOAD:  if (w_cnt_last) r_round <= 4'd1;
                ST_ROUND: if (w_rcon_step) r_round <= r_round + 4'd1;
                ST_OUT:   if (w_cnt_last) r_round <= 4'd0;
                default:  r_round <= 4'd0;
            endcase
        end
    end

    aes_rcon_gen u_rcon (
        .ClkxCI (ClkxCI),
        .RstxBI (RstxBI),
        .i_load (w_start),
        .i_step (w_rcon_step),
        .o_rcon (bus.RconxDO)
    );

    // MixColumns acts on the previous round's columns, so round 1 has none.
    assign bus.BusyxSO        = (r_state != ST_IDLE);
    assign bus.LoadxSO        = (r_state == ST_LOAD);
    assign bus.KeyStepxSO     = (r_state == ST_ROUND);
    assign bus.ShiftRowsxSO   = (r_state == ST_ROUND) && w_cnt_last;
    assign bus.MixColumnsxSO  = (r_state == ST_ROUND)
                                && (r_cnt[1:0] == 2'd0)
                                && (r_round >= 4'd2);
    assign bus.CipherValidxSO = (r_state == ST_OUT);
    assign bus.DonexSO        = (r_state == ST_OUT) && w_cnt_last;
    assign bus.RoundxDO       = r_round;

endmodule

// File: tb/tb_aes_ctrl_fsm.sv
// Self-checking bench for aes_ctrl_fsm: vector table, directed corner
// sequences and random Start/reset against a phase-level model.
module tb_aes_ctrl_fsm;

    typedef struct packed {
        logic       busy;
        logic       load;
        logic       sr;
        logic       mc;
        logic       ks;
        logic       cv;
        logic       done;
        logic [7:0] rcon;
        logic [3:0] round;
    } outs_t;

    typedef struct {
        int    k;
        outs_t exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    aes_ctrl_fsm_if bus ();

    aes_ctrl_fsm dut (
        .ClkxCI (clk),
        .RstxBI (rst_n),
        .bus    (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    vec_t       tab[$];
    logic [7:0] rc_tab[10];

    bit         m_act;
    int         m_k;
    logic [7:0] m_rc;

    function automatic outs_t dut_outs();
        return {bus.BusyxSO, bus.LoadxSO, bus.ShiftRowsxSO,
                bus.MixColumnsxSO, bus.KeyStepxSO, bus.CipherValidxSO,
                bus.DonexSO, bus.RconxDO, bus.RoundxDO};
    endfunction

    // Expected outputs from the position k inside a 192-cycle operation.
    function automatic outs_t model();
        outs_t o;
        int    ph;
        int    b;
        o      = '0;
        o.rcon = m_rc;
        if (m_act) begin
            ph     = m_k / 16;
            b      = m_k % 16;
            o.busy = 1'b1;
            if (ph == 0) begin
                o.load = 1'b1;
                o.rcon = 8'h01;
            end else if (ph <= 10) begin
                o.ks    = 1'b1;
                o.round = 4'(ph);
                o.rcon  = rc_tab[ph-1];
                o.sr    = (b == 15);
                o.mc    = (ph >= 2) && (b % 4 == 0);
            end else begin
                o.cv    = 1'b1;
                o.round = 4'd10;
                o.rcon  = 8'h36;
                o.done  = (b == 15);
            end
        end
        return o;
    endfunction

    task automatic model_reset();
        m_act = 1'b0;
        m_k   = 0;
        m_rc  = 8'h01;
    endtask

    task automatic chk(input string name, input outs_t act, input outs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input string name);
        bit s;
        bit r;
        s = bus.StartxSI;
        r = rst_n;
        @(posedge clk);
        #1;
        if (!r) begin
            model_reset();
        end else if (!m_act) begin
            if (s) begin
                m_act = 1'b1;
                m_k   = 0;
            end
        end else begin
            m_k++;
            if (m_k == 192) begin
                m_act = 1'b0;
                m_rc  = 8'h36;
            end
        end
        chk(name, dut_outs(), model());
    endtask

    task automatic async_reset(input string name);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk(name, dut_outs(), model());
    endtask

    task automatic add(input int k, input logic [6:0] f,
                       input logic [7:0] rc, input logic [3:0] rd);
        vec_t v;
        v.k   = k;
        v.exp = outs_t'({f, rc, rd});
        tab.push_back(v);
    endtask

    // Entered with the DUT in its first LOAD cycle; leaves it in IDLE.
    task automatic run_op(input string tag, input bit pulses);
        int    n_ld;
        int    n_sr;
        int    n_mc;
        int    n_ks;
        int    n_cv;
        int    n_dn;
        int    done_k;
        outs_t o;
        n_ld = 0; n_sr = 0; n_mc = 0;
        n_ks = 0; n_cv = 0; n_dn = 0;
        done_k = -1;
        for (int k = 0; k <= 192; k++) begin
            o = dut_outs();
            foreach (tab[i])
                if (tab[i].k == k)
                    chk($sformatf("%s_vec_k%0d", tag, k), o, tab[i].exp);
            if (k == 192) break;
            n_ld += int'(o.load);
            n_sr += int'(o.sr);
            n_mc += int'(o.mc);
            n_ks += int'(o.ks);
            n_cv += int'(o.cv);
            if (o.done) begin
                n_dn++;
                done_k = k;
            end
            bus.StartxSI = pulses && (k == 5 || k == 100 || k >= 185);
            tick(tag);
        end
        chk_int({tag, "_load_cnt"}, n_ld, 16);
        chk_int({tag, "_sr_cnt"}, n_sr, 10);
        chk_int({tag, "_mc_cnt"}, n_mc, 36);
        chk_int({tag, "_ks_cnt"}, n_ks, 160);
        chk_int({tag, "_cv_cnt"}, n_cv, 16);
        chk_int({tag, "_done_cnt"}, n_dn, 1);
        chk_int({tag, "_done_cycle"}, done_k, 191);
    endtask

    initial begin
        int rst_left;

        rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                   8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
        // fields: busy load sr mc ks cv done, rcon, round
        add(0,   7'b1100000, 8'h01, 4'd0);
        add(15,  7'b1100000, 8'h01, 4'd0);
        add(16,  7'b1000100, 8'h01, 4'd1);
        add(20,  7'b1000100, 8'h01, 4'd1);
        add(31,  7'b1010100, 8'h01, 4'd1);
        add(32,  7'b1001100, 8'h02, 4'd2);
        add(47,  7'b1010100, 8'h02, 4'd2);
        add(48,  7'b1001100, 8'h04, 4'd3);
        add(140, 7'b1001100, 8'h80, 4'd8);
        add(144, 7'b1001100, 8'h1B, 4'd9);
        add(172, 7'b1001100, 8'h36, 4'd10);
        add(175, 7'b1010100, 8'h36, 4'd10);
        add(176, 7'b1000010, 8'h36, 4'd10);
        add(191, 7'b1000011, 8'h36, 4'd10);
        add(192, 7'b0000000, 8'h36, 4'd0);

        bus.StartxSI = 1'b1;
        model_reset();
        #2;
        async_reset("reset_async");
        repeat (3) tick("reset_hold_start");

        rst_n = 1'b1;
        tick("reset_release_load");
        checks++;
        if (bus.LoadxSO !== 1'b1) begin
            errors++;
            $display("FAIL first_load: got %b expected 1", bus.LoadxSO);
        end
        bus.StartxSI = 1'b0;
        run_op("run1", 1'b0);

        repeat (3) tick("idle");
        bus.StartxSI = 1'b1;
        tick("start2");
        run_op("run2", 1'b1);
        tick("b2b_load");
        bus.StartxSI = 1'b0;

        for (int k = 0; k < 87; k++) tick("pre_abort");
        chk_int("abort_round", int'(bus.RoundxDO), 5);
        async_reset("abort_async");
        repeat (2) tick("abort_hold");
        rst_n = 1'b1;
        bus.StartxSI = 1'b1;
        tick("abort_restart");
        bus.StartxSI = 1'b0;
        run_op("run3", 1'b0);

        rst_left = 0;
        for (int c = 0; c < 3000; c++) begin
            bus.StartxSI = ($urandom_range(0, 7) == 0);
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                async_reset("rand_async");
                rst_left = 1 + $urandom_range(0, 2);
            end
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
